pixel_framebuffer: RTL
======================

Name: pixel_framebuffer

Overview:
Receiving end of the pixel-plot stream produced by the graphics datapath. Accepts (x, y, colour, plot) writes into a small input FIFO and drains them into an on-chip WIDTH x HEIGHT 3-bit frame store. On request, scans the whole store out in raster order over a valid/ready stream for the display or readback logic. A single-port memory is shared between the write drain and the scan reader, and the scan reader has priority.

Parameters:
WIDTH, 160, pixels per row; x range 0..WIDTH-1
HEIGHT, 120, rows; y range 0..HEIGHT-1
FIFO_DEPTH, 4, input write FIFO entries (power of 2, >=2)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
plot  in  1  write request; accepted when plot && write_ready
x_in  in  8  pixel x
y_in  in  8  pixel y
colour_in  in  3  pixel colour
write_ready  out  1  high when FIFO not full
scan_start  in  1  begin a frame scan; honoured only in IDLE
scan_ready  in  1  downstream accepts scan pixel
scan_valid  out  1  scan_x/scan_y/scan_colour valid
scan_x  out  8  x of presented pixel
scan_y  out  8  y of presented pixel
scan_colour  out  3  stored colour at (scan_x, scan_y)
scan_busy  out  1  high in SCAN state
frame_done  out  1  one-cycle pulse when the last pixel is accepted downstream
oob_count  out  8  out-of-bounds write counter (see Optional Feature)

Behaviour:
- Reset: FIFO empty, write_ready=1, state IDLE, scan_valid=0, scan_x/scan_y/scan_colour=0, scan_busy=0, frame_done=0, oob_count=0. Memory contents are not cleared by reset.
- Address = y*WIDTH + x, computed at memory-port width (ceil(log2(WIDTH*HEIGHT)) bits).
- Write side: write_ready = !full, taken from the registered count. There is no pass-through. A plot while full is ignored, and the pixel is lost.
- A FIFO push and pop in the same cycle both occur; the count is unchanged.
- Drain: one FIFO entry is written to memory per cycle in which the port is not claimed by a scan read.
- FIFO order is preserved. A later write to the same address wins.
- Scan FSM states: IDLE, SCAN, FLUSH.
  - IDLE -> SCAN on scan_start. The read pointer is set to (0,0).
  - SCAN: a read is issued when no read is outstanding and (!scan_valid or scan_ready). Issuing a read claims the memory port that cycle.
  - Read latency is 1 cycle. Data loads scan_colour, scan_x and scan_y, and sets scan_valid.
  - The pointer advances x+1. At x=WIDTH-1 it wraps to x=0, y+1.
  - After issuing the read for (WIDTH-1, HEIGHT-1), go to FLUSH.
  - FLUSH: wait until the final pixel is accepted (scan_valid && scan_ready). Pulse frame_done that cycle, clear scan_valid, return to IDLE.
- scan_valid, once high, holds with stable data until scan_ready.
- Throughput with scan_ready held high is 1 pixel/cycle. The first scan_valid appears 2 cycles after scan_start.
- scan_start while in SCAN or FLUSH is ignored.
- Writes are starved during active scan reads and resume whenever a read is not issued.
- Reset mid-scan aborts the scan; all outputs take reset values next cycle.

Optional Feature:
Macro PIXEL_FRAMEBUFFER_BOUNDS_CHECK_EN.
- Defined:
  - A write with x_in>=WIDTH or y_in>=HEIGHT is still accepted (it consumes the handshake) but is not pushed to the FIFO.
  - oob_count increments, saturating at 255.
- Undefined:
  - No check is made; the address is truncated to memory-port width and may alias other pixels.
  - oob_count is tied to 0.

Test Plan:
- Reset, then plot (3,2,colour 5) and (0,0,colour 1). Wait 4 cycles, pulse scan_start, hold scan_ready=1. Required: first beat (0,0,1) on the 2nd cycle after scan_start; beat index 323 is (3,2,5); 19200 beats total; frame_done on the last beat (159,119).
- Hold plot=1 with scan running and scan_ready=1. Required: write_ready falls after 4 accepted writes; no write lands until the scan ends; all 4 are stored after the frame.
- Toggle scan_ready 1/0 every cycle during a scan. Required: each beat is held stable while scan_ready=0; no pixel is skipped or duplicated; 19200 beats; frame_done once.
- Plot (10,10,2) then (10,10,6) back-to-back, then scan. Required: (10,10) reads 6.
- Assert reset at beat 500 of a scan. Required: scan_valid=0, scan_busy=0 the next cycle. A new scan_start restarts at (0,0).
- With PIXEL_FRAMEBUFFER_BOUNDS_CHECK_EN, plot (160,0,3) and (0,120,3). Required: oob_count=2, no memory change. Without the macro, oob_count stays 0.

Source files
------------

// File: rtl/pixel_framebuffer_if.sv
// Pixel-plot write stream and raster scan-out stream of the frame buffer.
// master: the side that plots pixels and consumes the scan.
// slave: the frame buffer itself.
interface pixel_framebuffer_if;
  logic       plot;
  logic [7:0] x_in;
  logic [7:0] y_in;
  logic [2:0] colour_in;
  logic       write_ready;
  logic       scan_start;
  logic       scan_ready;
  logic       scan_valid;
  logic [7:0] scan_x;
  logic [7:0] scan_y;
  logic [2:0] scan_colour;
  logic       scan_busy;
  logic       frame_done;
  logic [7:0] oob_count;

  modport master (
    output plot, x_in, y_in, colour_in, scan_start, scan_ready,
    input  write_ready, scan_valid, scan_x, scan_y, scan_colour,
           scan_busy, frame_done, oob_count
  );

  modport slave (
    input  plot, x_in, y_in, colour_in, scan_start, scan_ready,
    output write_ready, scan_valid, scan_x, scan_y, scan_colour,
           scan_busy, frame_done, oob_count
  );
endinterface

// File: rtl/pixel_framebuffer.sv
// Pixel frame buffer: (x, y, colour) writes go through a small FIFO into a
// WIDTH x HEIGHT 3-bit single-port store; a raster scan-out reads the whole
// store over a valid/ready stream and has priority on the memory port.
// Optional macro PIXEL_FRAMEBUFFER_BOUNDS_CHECK_EN drops out-of-range writes
// and counts them in oob_count (saturating); otherwise addresses are
// truncated and oob_count is 0.
module pixel_framebuffer #(
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             clock,
  input logic             reset,
  pixel_framebuffer_if.slave bus
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t        state;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [2:0]    fifo_colour [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic          rd_en;
  logic          last_pixel;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_x;
  logic [7:0]    rd_y;
  logic [7:0]    scan_x;
  logic [7:0]    scan_y;
  logic [2:0]    scan_colour;
  logic          scan_valid;
  logic [7:0]    oob_count;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign accept  = bus.plot && !full;
  assign wr_addr = AW'(bus.y_in) * AW'(WIDTH) + AW'(bus.x_in);
  assign rd_addr = AW'(rd_y) * AW'(WIDTH) + AW'(rd_x);

  // A scan read claims the port whenever the output slot is free or draining.
  assign rd_en      = (state == SCAN) && (!scan_valid || bus.scan_ready);
  assign pop        = !empty && !rd_en;
  assign last_pixel = (rd_x == 8'(WIDTH - 1)) && (rd_y == 8'(HEIGHT - 1));

`ifdef PIXEL_FRAMEBUFFER_BOUNDS_CHECK_EN
  logic oob;

  assign oob  = (32'(bus.x_in) >= WIDTH) || (32'(bus.y_in) >= HEIGHT);
  assign push = accept && !oob;

  // Count handshaken writes that fall outside the frame, saturating.
  always_ff @(posedge clock) begin
    if (reset) begin
      oob_count <= '0;
    end else if (accept && oob && (oob_count != '1)) begin
      oob_count <= oob_count + 8'd1;
    end
  end
`else
  assign push      = accept;
  assign oob_count = '0;
`endif

  // Input FIFO: storage plus pointers; simultaneous push and pop keep count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr]   <= wr_addr;
        fifo_colour[wr_ptr] <= bus.colour_in;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Single memory port: scan read (data lands straight in scan_colour) wins over drain write.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_colour <= '0;
    end else if (rd_en) begin
      scan_colour <= mem[rd_addr];
    end else if (pop) begin
      mem[fifo_addr[rd_ptr]] <= fifo_colour[rd_ptr];
    end
  end

  // Scan FSM: raster pointer, presented coordinates and output valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rd_x       <= '0;
      rd_y       <= '0;
      scan_x     <= '0;
      scan_y     <= '0;
      scan_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.scan_start) begin
            state <= SCAN;
            rd_x  <= '0;
            rd_y  <= '0;
          end
        end
        SCAN: begin
          if (rd_en) begin
            scan_valid <= 1'b1;
            scan_x     <= rd_x;
            scan_y     <= rd_y;
            if (last_pixel) begin
              state <= FLUSH;
            end else if (rd_x == 8'(WIDTH - 1)) begin
              rd_x <= '0;
              rd_y <= rd_y + 8'd1;
            end else begin
              rd_x <= rd_x + 8'd1;
            end
          end
        end
        FLUSH: begin
          if (scan_valid && bus.scan_ready) begin
            scan_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.write_ready = !full;
  assign bus.scan_valid  = scan_valid;
  assign bus.scan_x      = scan_x;
  assign bus.scan_y      = scan_y;
  assign bus.scan_colour = scan_colour;
  assign bus.scan_busy   = (state == SCAN);
  assign bus.frame_done  = (state == FLUSH) && scan_valid && bus.scan_ready;
  assign bus.oob_count   = oob_count;

endmodule
